// File: rtl/bounce_pkg.sv
// Shared types and defaults for the bouncing-square motion scheduler.
package bounce_pkg;

  localparam int CORDW_DEF = 10;

  typedef struct packed {
    logic [CORDW_DEF-1:0] x;
    logic [CORDW_DEF-1:0] y;
    logic [CORDW_DEF-1:0] size;
    logic [CORDW_DEF-1:0] speed;
    logic                 dx;
    logic                 dy;
  } obj_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UPD_X = 2'd1,
    ST_UPD_Y = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  typedef enum logic {
    AXIS_X = 1'b0,
    AXIS_Y = 1'b1
  } axis_sel_t;

endpackage

// File: rtl/bounce_axis.sv
// Combinational single-axis next-position/next-direction unit.
// Define BOUNCE_SCHED_WRAP_EN to wrap at the screen edges instead of bouncing.
module bounce_axis
  import bounce_pkg::*;
#(
  parameter int CORDW = CORDW_DEF
) (
  input  logic [CORDW-1:0] pos,
  input  logic             dir,
  input  logic [CORDW-1:0] size,
  input  logic [CORDW-1:0] speed,
  input  logic [CORDW-1:0] limit,
  output logic [CORDW-1:0] pos_next,
  output logic             dir_next
);

  localparam int LW = CORDW + 2;

  logic signed [LW-1:0] lim;
  logic signed [LW-1:0] pos_s;
  logic signed [LW-1:0] spd_s;
`ifdef BOUNCE_SCHED_WRAP_EN
  logic signed [LW-1:0] span;
`endif

  // Next position/direction; a negative lim means the square cannot move on this axis.
  always_comb begin
    pos_s    = $signed({2'b00, pos});
    spd_s    = $signed({2'b00, speed});
    lim      = $signed({2'b00, limit}) - $signed({2'b00, size}) - spd_s;
    pos_next = pos;
    dir_next = dir;
`ifdef BOUNCE_SCHED_WRAP_EN
    span     = $signed({2'b00, limit}) - $signed({2'b00, size});
    if (lim[LW-1]) begin
      pos_next = pos;
    end else if (!dir) begin
      pos_next = (pos_s + spd_s > span) ? CORDW'(pos_s + spd_s - span) : pos + speed;
    end else begin
      pos_next = (pos_s < spd_s) ? CORDW'(pos_s - spd_s + span) : pos - speed;
    end
`else
    if (lim[LW-1]) begin
      pos_next = pos;
    end else if (pos_s >= lim) begin
      dir_next = 1'b1;
      pos_next = pos - speed;
    end else if (pos_s < spd_s) begin
      dir_next = 1'b0;
      pos_next = pos + speed;
    end else begin
      pos_next = dir ? pos - speed : pos + speed;
    end
`endif
  end

endmodule

// File: rtl/bounce_sched.sv
// Time-multiplexed motion controller: one shared axis unit walks every object (x then y)
// on each frame_start. Optional wrap mode via BOUNCE_SCHED_WRAP_EN (see bounce_axis).
module bounce_sched
  import bounce_pkg::*;
#(
  parameter int NUM_OBJ = 4,
  parameter int CORDW   = CORDW_DEF,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480
) (
  input  logic                     clk_pix,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [3:0]               cfg_idx,
  input  logic [CORDW-1:0]         cfg_x,
  input  logic [CORDW-1:0]         cfg_y,
  input  logic [CORDW-1:0]         cfg_size,
  input  logic [CORDW-1:0]         cfg_speed,
  input  logic                     cfg_dx,
  input  logic                     cfg_dy,
  output logic [NUM_OBJ*CORDW-1:0] obj_x,
  output logic [NUM_OBJ*CORDW-1:0] obj_y,
  output logic [NUM_OBJ*CORDW-1:0] obj_size,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_UPD_X = ST_UPD_X;
  localparam logic [1:0] S_UPD_Y = ST_UPD_Y;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]       state, next_state;
  logic [3:0]       idx;
  logic             pending;
  logic             cfg_we;
  logic [CORDW-1:0] px [NUM_OBJ];
  logic [CORDW-1:0] py [NUM_OBJ];
  logic [CORDW-1:0] psz[NUM_OBJ];
  logic [CORDW-1:0] psp[NUM_OBJ];
  logic             pdx[NUM_OBJ];
  logic             pdy[NUM_OBJ];

  logic [CORDW-1:0] cur_x, cur_y, cur_size, cur_speed;
  logic             cur_dx, cur_dy;
  axis_sel_t        axis;
  logic [CORDW-1:0] a_pos, a_limit, a_pos_next;
  logic             a_dir, a_dir_next;

  assign cfg_we = cfg_valid && cfg_ready;

  // Select the object under update and route the active axis into the shared unit.
  always_comb begin
    cur_x     = '0;
    cur_y     = '0;
    cur_size  = '0;
    cur_speed = '0;
    cur_dx    = 1'b0;
    cur_dy    = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      cur_x     = (idx == 4'(i)) ? px[i]  : cur_x;
      cur_y     = (idx == 4'(i)) ? py[i]  : cur_y;
      cur_size  = (idx == 4'(i)) ? psz[i] : cur_size;
      cur_speed = (idx == 4'(i)) ? psp[i] : cur_speed;
      cur_dx    = (idx == 4'(i)) ? pdx[i] : cur_dx;
      cur_dy    = (idx == 4'(i)) ? pdy[i] : cur_dy;
    end
    axis    = (state == S_UPD_Y) ? AXIS_Y : AXIS_X;
    a_pos   = (axis == AXIS_Y) ? cur_y : cur_x;
    a_dir   = (axis == AXIS_Y) ? cur_dy : cur_dx;
    a_limit = (axis == AXIS_Y) ? CORDW'(V_RES) : CORDW'(H_RES);
  end

  bounce_axis #(.CORDW(CORDW)) u_axis (
    .pos      (a_pos),
    .dir      (a_dir),
    .size     (cur_size),
    .speed    (cur_speed),
    .limit    (a_limit),
    .pos_next (a_pos_next),
    .dir_next (a_dir_next)
  );

  // Sequencer next state; a start coinciding with a cfg write is deferred one cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (pending) begin
          next_state = S_UPD_X;
        end else if (frame_start && !cfg_we) begin
          next_state = S_UPD_X;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_UPD_X: next_state = S_UPD_Y;
      S_UPD_Y: next_state = (idx == 4'(NUM_OBJ - 1)) ? S_DONE : S_UPD_X;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Sequencer registers and registered status outputs.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      pending   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      state     <= next_state;
      pending   <= (state == S_IDLE) && !pending && frame_start && cfg_we;
      busy      <= (next_state != S_IDLE);
      done      <= (next_state == S_DONE);
      overrun   <= frame_start && (state != S_IDLE);
      cfg_ready <= (next_state == S_IDLE);
      if (state == S_IDLE) begin
        idx <= 4'd0;
      end else if (state == S_UPD_Y) begin
        idx <= idx + 4'd1;
      end else begin
        idx <= idx;
      end
    end
  end

  // Object state: cfg writes only happen in IDLE, write-back only in UPD_X/UPD_Y.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        px[i]  <= '0;
        py[i]  <= '0;
        psz[i] <= '0;
        psp[i] <= CORDW'(1);
        pdx[i] <= 1'b0;
        pdy[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (cfg_we && cfg_idx == 4'(i)) begin
          px[i]  <= cfg_x;
          py[i]  <= cfg_y;
          psz[i] <= cfg_size;
          psp[i] <= cfg_speed;
          pdx[i] <= cfg_dx;
          pdy[i] <= cfg_dy;
        end else if (state == S_UPD_X && idx == 4'(i) && psz[i] != '0) begin
          px[i]  <= a_pos_next;
          pdx[i] <= a_dir_next;
        end else if (state == S_UPD_Y && idx == 4'(i) && psz[i] != '0) begin
          py[i]  <= a_pos_next;
          pdy[i] <= a_dir_next;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_flat
    assign obj_x[g*CORDW +: CORDW]    = px[g];
    assign obj_y[g*CORDW +: CORDW]    = py[g];
    assign obj_size[g*CORDW +: CORDW] = psz[g];
  end

endmodule

// File: tb/tb_bounce_sched.sv
// Self-checking bench for bounce_sched: directed scenarios plus randomized frames
// checked against a rule-level reference model.
module tb_bounce_sched;
  import bounce_pkg::*;

  localparam int NUM_OBJ = 4;
  localparam int CORDW   = 10;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int SEQ_DONE = 2 * NUM_OBJ + 1;

  logic                     clk_pix = 1'b0;
  logic                     rst_n;
  logic                     frame_start;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [3:0]               cfg_idx;
  logic [CORDW-1:0]         cfg_x, cfg_y, cfg_size, cfg_speed;
  logic                     cfg_dx, cfg_dy;
  logic [NUM_OBJ*CORDW-1:0] obj_x, obj_y, obj_size;
  logic                     busy, done, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  obj_t m [NUM_OBJ];

  always #5 clk_pix = ~clk_pix;

  bounce_sched #(.NUM_OBJ(NUM_OBJ), .CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES)) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame_start(frame_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_size(cfg_size), .cfg_speed(cfg_speed),
    .cfg_dx(cfg_dx), .cfg_dy(cfg_dy),
    .obj_x(obj_x), .obj_y(obj_y), .obj_size(obj_size),
    .busy(busy), .done(done), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  // Reference axis rule; returns {dir, pos} packed as dir*1024 + pos.
  function automatic int axis_ref(int pos, int dir, int size, int speed, int limit);
    int lim;
    int p;
    int d;
    int span;
    lim  = limit - (size + speed);
    span = limit - size;
    p    = pos;
    d    = dir;
    if (lim >= 0) begin
`ifdef BOUNCE_SCHED_WRAP_EN
      if (d == 0) p = (pos + speed > span) ? pos + speed - span : pos + speed;
      else        p = (pos < speed) ? pos - speed + span : pos - speed;
`else
      if (pos >= lim)       begin d = 1; p = pos - speed; end
      else if (pos < speed) begin d = 0; p = pos + speed; end
      else                  p = (d != 0) ? pos - speed : pos + speed;
`endif
    end
    p = ((p % 1024) + 1024) % 1024;
    return d * 1024 + p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_OBJ; i++) begin
      m[i] = '0;
      m[i].speed = CORDW'(1);
    end
  endtask

  task automatic model_write(int idx, int x, int y, int sz, int sp, int dx, int dy);
    if (idx < NUM_OBJ) begin
      m[idx].x = CORDW'(x); m[idx].y = CORDW'(y);
      m[idx].size = CORDW'(sz); m[idx].speed = CORDW'(sp);
      m[idx].dx = dx[0]; m[idx].dy = dy[0];
    end
  endtask

  task automatic model_frame();
    int r;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (m[i].size != '0) begin
        r = axis_ref(int'(m[i].x), int'(m[i].dx), int'(m[i].size), int'(m[i].speed), H_RES);
        m[i].x = CORDW'(r % 1024); m[i].dx = (r >= 1024);
        r = axis_ref(int'(m[i].y), int'(m[i].dy), int'(m[i].size), int'(m[i].speed), V_RES);
        m[i].y = CORDW'(r % 1024); m[i].dy = (r >= 1024);
      end
    end
  endtask

  task automatic drive_cfg(int idx, int x, int y, int sz, int sp, int dx, int dy);
    cfg_valid = 1'b1; cfg_idx = 4'(idx);
    cfg_x = CORDW'(x); cfg_y = CORDW'(y); cfg_size = CORDW'(sz); cfg_speed = CORDW'(sp);
    cfg_dx = dx[0]; cfg_dy = dy[0];
    model_write(idx, x, y, sz, sp, dx, dy);
  endtask

  task automatic cfg_write(int idx, int x, int y, int sz, int sp, int dx, int dy);
    drive_cfg(idx, x, y, sz, sp, dx, dy);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < NUM_OBJ; i++) begin
      check($sformatf("%s_x%0d", tag, i), 32'(obj_x[i*CORDW +: CORDW]), 32'(m[i].x));
      check($sformatf("%s_y%0d", tag, i), 32'(obj_y[i*CORDW +: CORDW]), 32'(m[i].y));
      check($sformatf("%s_s%0d", tag, i), 32'(obj_size[i*CORDW +: CORDW]), 32'(m[i].size));
    end
  endtask

  // One frame; if pend, the caller has already driven a cfg write for the same cycle.
  task automatic run_frame(input string tag, input bit pend);
    int dc;
    dc = -1;
    frame_start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      frame_start = 1'b0;
      cfg_valid   = 1'b0;
      if (c == 1) check({tag, "_busy_c1"}, 32'(busy), pend ? 32'd0 : 32'd1);
      if (c == 2 && pend) check({tag, "_busy_c2"}, 32'(busy), 32'd1);
      if (done) begin
        dc = c;
        break;
      end
    end
    check({tag, "_done_cyc"}, 32'(dc), 32'(SEQ_DONE + (pend ? 1 : 0)));
    model_frame();
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_ready"}, 32'(cfg_ready), 32'd1);
    compare_all(tag);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; frame_start = 1'b0; cfg_valid = 1'b0; cfg_idx = 4'd0;
    cfg_x = '0; cfg_y = '0; cfg_size = '0; cfg_speed = '0; cfg_dx = 1'b0; cfg_dy = 1'b0;
    model_reset();
    #23;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    compare_all("rst");
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(cfg_ready), 32'd1);

    cfg_write(0, 10, 10, 100, 3, 0, 0);
    run_frame("basic", 1'b0);

    cfg_write(0, 538, 10, 100, 3, 0, 0);
    cfg_write(1, 2, 20, 50, 3, 1, 0);
    run_frame("edge1", 1'b0);
    run_frame("edge2", 1'b0);

    drive_cfg(2, 50, 30, 20, 2, 0, 0);
    run_frame("pend", 1'b1);

    // Overrun: second frame_start in cycle 4 of a running sequence.
    dones = 0;
    frame_start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      frame_start = (c == 4) ? 1'b1 : 1'b0;
      if (c == 5) check("ovr_pulse", 32'(overrun), 32'd1);
      if (c == 6) check("ovr_single", 32'(overrun), 32'd0);
      if (done) dones++;
    end
    check("ovr_dones", 32'(dones), 32'd1);
    model_frame();
    compare_all("ovr");

    cfg_write(3, 7, 8, 600, 50, 0, 1);
    cfg_write(1, 100, 100, 0, 5, 0, 0);
    run_frame("degen", 1'b0);

    cfg_write(9, 1, 2, 3, 4, 1, 1);
    compare_all("dropped");

    // Asynchronous reset while obj1 y is being updated (cycle 4).
    frame_start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      frame_start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(cfg_ready), 32'd0);
    compare_all("arst");
    #2 rst_n = 1'b1;
    tick();
    run_frame("post_rst", 1'b0);

    for (int it = 0; it < 30; it++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) begin
        int sz;
        case ($urandom_range(0, 5))
          0:       sz = 0;
          1:       sz = int'($urandom_range(550, 900));
          default: sz = int'($urandom_range(1, 200));
        endcase
        cfg_write(int'($urandom_range(0, 5)), int'($urandom_range(0, 639)),
                  int'($urandom_range(0, 479)), sz, int'($urandom_range(0, 20)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) == 0) begin
        drive_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 639)),
                  int'($urandom_range(0, 479)), int'($urandom_range(1, 150)),
                  int'($urandom_range(1, 10)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)));
        run_frame($sformatf("rnd%0d", it), 1'b1);
      end else begin
        run_frame($sformatf("rnd%0d", it), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bounce_sched.md
Name: bounce_sched

Overview:
- Time-multiplexed motion controller for the bouncing-square display path.
- Holds position, direction, size and speed for NUM_OBJ squares.
- On each frame_start pulse (start of vertical blanking), sequences one shared single-axis update unit over every object: x first, then y.
- Presents all positions to the draw logic. Accepts runtime configuration through a valid/ready port.

Parameters:
- NUM_OBJ, 4, number of squares managed (1..16).
- CORDW, 10, screen coordinate width in bits.
- H_RES, 640, active horizontal pixels (x bounce limit).
- V_RES, 480, active vertical lines (y bounce limit).

Ports:
- clk_pix  in  1  pixel clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of blanking (sy==V_RES, sx==0).
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  high when a configuration write can be accepted.
- cfg_idx  in  4  object index.
- cfg_x, cfg_y  in  CORDW  new position.
- cfg_size  in  CORDW  square size in pixels; 0 disables the object.
- cfg_speed  in  CORDW  pixels moved per frame on each axis.
- cfg_dx, cfg_dy  in  1  direction; 0 = right/down.
- obj_x, obj_y, obj_size  out  NUM_OBJ*CORDW  flattened per-object state; object i occupies bits [i*CORDW +: CORDW].
- busy  out  1  update sequence in progress.
- done  out  1  one-cycle pulse after the last object is written.
- overrun  out  1  one-cycle pulse when frame_start arrives while busy.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All x, y, size = 0; speed = 1; dx = dy = 0.
  - FSM in IDLE; busy = 0, done = 0, overrun = 0, cfg_ready = 0.
  - Pending-start flag cleared.
  - rst_n asserted mid-sequence aborts the sequence; no partial-state guarantee beyond the reset values.
- FSM states: IDLE, UPD_X, UPD_Y, DONE.
  - IDLE -> UPD_X with idx = 0 on frame_start, or on the pending flag.
  - UPD_X -> UPD_Y (x and dx written).
  - UPD_Y -> UPD_X with idx+1, or -> DONE when idx == NUM_OBJ-1 (y and dy written).
  - DONE -> IDLE; done = 1 for exactly this cycle.
- Latency: frame_start in cycle 0 gives busy = 1 from cycle 1, done in cycle 2*NUM_OBJ+1, IDLE in cycle 2*NUM_OBJ+2.
- cfg_ready = (state == IDLE) and rst_n deasserted.
  - A write is accepted when cfg_valid and cfg_ready; all fields of object cfg_idx are written next edge.
  - cfg_idx >= NUM_OBJ: accepted but dropped.
- frame_start and an accepted cfg write in the same cycle: the write takes effect and the pending flag is set. The sequence starts the following cycle using the new values.
- frame_start while busy or in DONE: ignored; overrun pulses for one cycle.
- Axis update, one axis per cycle: inputs pos, dir, size, speed, limit (H_RES for x, V_RES for y). Compute lim = limit - (size + speed) in CORDW+2 bits, signed.
  - If lim < 0: pos and dir held (degenerate object).
  - Else if pos >= lim: dir = 1, pos = pos - speed.
  - Else if pos < speed: dir = 0, pos = pos + speed.
  - Else pos = dir ? pos - speed : pos + speed.
- Objects with size == 0 are skipped: the cycle is still spent and state is unchanged.
- Outputs are registered. obj_* change only at write-back edges and cfg writes.

Optional Feature:
- Macro: BOUNCE_SCHED_WRAP_EN.
- Defined:
  - The axis unit wraps instead of bouncing.
  - Moving right/down past limit-size gives pos = pos + speed - (limit - size).
  - Moving left/up with pos < speed gives pos = pos - speed + (limit - size).
  - dir never changes.
- Undefined: bounce rule above; wrap logic is absent.

Decomposition:
- Package bounce_pkg:
  - CORDW_DEF.
  - obj_t struct: x, y, size, speed, dx, dy.
  - sched_state_t enum.
  - axis_sel_t enum (AXIS_X, AXIS_Y).
- Sub-module bounce_axis: purely combinational single-axis next-position/next-direction unit, instanced once and shared by the FSM. Holds the WRAP_EN variant.

Test Plan:
- Reset, then configure obj0 x=10, y=10, size=100, speed=3; one frame_start -> done at cycle 9 (NUM_OBJ=4); obj0 x=13, y=13.
- obj0 x=538, size=100, speed=3, dx=0; frame_start -> x=535, dx=1. obj1 x=2, speed=3, dx=1 -> x=5, dx=0.
- frame_start with cfg_valid in the same IDLE cycle (obj2 x=50, speed=2) -> write applied; busy rises one cycle later; obj2 x=52.
- Second frame_start at cycle 4 of a sequence -> overrun pulse; exactly one done; positions advanced once.
- size=600, speed=50 on x (lim<0) -> x and dx unchanged. size=0 object -> unchanged; sequence length still 2*NUM_OBJ.
- rst_n low during UPD_Y of obj1 -> all outputs at reset values immediately; next frame_start runs a full sequence. With BOUNCE_SCHED_WRAP_EN: x=538, size=100, speed=3, dx=0 -> x=1, dx=0.
